// File: rtl/line_buf_sched.sv
`default_nettype none
// ============================================================================
//  Module      : line_buf_sched
//  Description : Sequencer for a bank of LINES_NUM line buffers forming a
//                sliding vertical window. Steers incoming lines to one buffer,
//                pops all buffers once a fresh window is complete, then
//                flushes the oldest line so it can take the next input line.
//  Revision    : 1.0 - initial release
// ============================================================================
module line_buf_sched #(
    parameter int LINES_NUM = 3,
    parameter int IDX_W     = $clog2(LINES_NUM)
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 in_tvalid_i,
    input  logic                 in_tready_i,
    input  logic                 in_tlast_i,
    input  logic                 in_tuser_i,
    input  logic                 out_tvalid_i,
    input  logic                 out_tready_i,
    input  logic                 out_tlast_i,
    input  logic [LINES_NUM-1:0] empty_i,
    output logic [LINES_NUM-1:0] wr_sel_o,
    output logic [LINES_NUM-1:0] pop_line_o,
    output logic [LINES_NUM-1:0] flush_line_o,
    output logic [IDX_W-1:0]     oldest_idx_o,
    output logic [IDX_W:0]       lines_cnt_o,
    output logic                 busy_o
);

    typedef enum logic [1:0] {
        ST_FILL  = 2'd0,
        ST_POP   = 2'd1,
        ST_SEND  = 2'd2,
        ST_FLUSH = 2'd3
    } state_t;

    localparam logic [IDX_W:0]       C_LINES_MAX = (IDX_W+1)'(LINES_NUM);
    localparam logic [IDX_W-1:0]     C_LAST_IDX  = IDX_W'(LINES_NUM - 1);
    localparam logic [LINES_NUM-1:0] C_ONE       = LINES_NUM'(1);

    // Index increment with explicit wrap so non-power-of-2 banks work.
    function automatic logic [IDX_W-1:0] wrap_inc(input logic [IDX_W-1:0] x);
        return (x == C_LAST_IDX) ? '0 : x + 1'b1;
    endfunction

    function automatic logic [LINES_NUM-1:0] onehot(input logic [IDX_W-1:0] x);
        return C_ONE << x;
    endfunction

    state_t                 r_state;
    logic [IDX_W-1:0]       r_wr_idx;
    logic [IDX_W-1:0]       r_oldest;
    logic [IDX_W:0]         r_cnt;
    logic                   r_pending;
    logic [LINES_NUM-1:0]   r_wr_sel;
    logic [LINES_NUM-1:0]   r_pop;
    logic [LINES_NUM-1:0]   r_flush;

    state_t                 w_state_nxt;
    logic [IDX_W-1:0]       w_wr_idx_nxt;
    logic [IDX_W-1:0]       w_oldest_nxt;
    logic [IDX_W:0]         w_cnt_nxt;
    logic                   w_pending_nxt;
    logic [LINES_NUM-1:0]   w_pop_nxt;
    logic [LINES_NUM-1:0]   w_flush_nxt;

    logic                   w_in_acc;
    logic                   w_eol;
    logic                   w_sof;
    logic                   w_out_eol;

    assign w_in_acc  = in_tvalid_i && in_tready_i;
    assign w_eol     = w_in_acc && in_tlast_i;
    assign w_sof     = w_in_acc && in_tuser_i;
    assign w_out_eol = out_tvalid_i && out_tready_i && out_tlast_i;

    // State and all registered outputs; wr_sel tracks the next write index so
    // it moves on the same edge the line buffer locks after end-of-line.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state   <= ST_FILL;
            r_wr_idx  <= '0;
            r_oldest  <= '0;
            r_cnt     <= '0;
            r_pending <= 1'b0;
            r_wr_sel  <= C_ONE;
            r_pop     <= '0;
            r_flush   <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_wr_idx  <= w_wr_idx_nxt;
            r_oldest  <= w_oldest_nxt;
            r_cnt     <= w_cnt_nxt;
            r_pending <= w_pending_nxt;
            r_wr_sel  <= onehot(w_wr_idx_nxt);
            r_pop     <= w_pop_nxt;
            r_flush   <= w_flush_nxt;
        end
    end

    // Next-state and next-output decode; start-of-frame overrides everything.
    always_comb begin
        w_state_nxt   = r_state;
        w_wr_idx_nxt  = r_wr_idx;
        w_oldest_nxt  = r_oldest;
        w_cnt_nxt     = r_cnt;
        w_pending_nxt = r_pending;
        w_pop_nxt     = '0;
        w_flush_nxt   = '0;

        if (w_sof) begin
            // Any in-flight window is abandoned; buffers self-clear on tuser.
            w_state_nxt  = ST_FILL;
            w_oldest_nxt = '0;
            if (w_eol) begin
                w_cnt_nxt     = (IDX_W+1)'(1);
                w_wr_idx_nxt  = wrap_inc('0);
                w_pending_nxt = 1'b1;
            end else begin
                w_cnt_nxt     = '0;
                w_wr_idx_nxt  = '0;
                w_pending_nxt = 1'b0;
            end
        end else begin
            case (r_state)
                ST_FILL: begin
                    if (w_eol) begin
                        w_pending_nxt = 1'b1;
                        // Once the window is full the write index stays on the
                        // buffer freed by the last flush.
                        if (r_cnt < C_LINES_MAX) begin
                            w_cnt_nxt    = r_cnt + 1'b1;
                            w_wr_idx_nxt = wrap_inc(r_wr_idx);
                        end
                    end
                    if ((r_cnt == C_LINES_MAX) && r_pending && (empty_i == '0)) begin
                        w_state_nxt = ST_POP;
                    end
                end
                ST_POP: begin
                    w_pop_nxt     = '1;
                    w_pending_nxt = 1'b0;
                    w_state_nxt   = ST_SEND;
                end
                ST_SEND: begin
                    if (w_eol) begin
                        w_pending_nxt = 1'b1;
                    end
                    if (w_out_eol) begin
                        w_state_nxt = ST_FLUSH;
                    end
                end
                ST_FLUSH: begin
                    // The oldest row leaves the window and becomes the write target.
                    w_flush_nxt  = onehot(r_oldest);
                    w_wr_idx_nxt = r_oldest;
                    w_oldest_nxt = wrap_inc(r_oldest);
                    w_state_nxt  = ST_FILL;
                end
                default: begin
                    w_state_nxt = ST_FILL;
                end
            endcase
        end
    end

    assign wr_sel_o     = r_wr_sel;
    assign pop_line_o   = r_pop;
    assign flush_line_o = r_flush;
    assign oldest_idx_o = r_oldest;
    assign lines_cnt_o  = r_cnt;
    assign busy_o       = (r_state != ST_FILL);

endmodule
`default_nettype wire

// File: tb/tb_line_buf_sched.sv
`default_nettype none
// ============================================================================
//  Module      : tb_line_buf_sched
//  Description : Directed self-checking bench for line_buf_sched, one
//                instance with a 3-line window and one with a 5-line window.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_line_buf_sched;

    logic clk_i = 1'b0;
    logic rst_i = 1'b0;
    always #5 clk_i = ~clk_i;

    // 3-line instance
    logic       a_in_tvalid = 0, a_in_tready = 0, a_in_tlast = 0, a_in_tuser = 0;
    logic       a_out_tvalid = 0, a_out_tready = 0, a_out_tlast = 0;
    logic [2:0] a_empty = '0;
    logic [2:0] a_wr_sel, a_pop, a_flush;
    logic [1:0] a_oldest;
    logic [2:0] a_cnt;
    logic       a_busy;

    // 5-line instance
    logic       b_in_tvalid = 0, b_in_tready = 0, b_in_tlast = 0, b_in_tuser = 0;
    logic       b_out_tvalid = 0, b_out_tready = 0, b_out_tlast = 0;
    logic [4:0] b_empty = '0;
    logic [4:0] b_wr_sel, b_pop, b_flush;
    logic [2:0] b_oldest;
    logic [3:0] b_cnt;
    logic       b_busy;

    int checks   = 0;
    int failures = 0;
    int b_pops   = 0;

    line_buf_sched #(.LINES_NUM(3)) u_dut_a (
        .clk_i(clk_i), .rst_i(rst_i),
        .in_tvalid_i(a_in_tvalid), .in_tready_i(a_in_tready),
        .in_tlast_i(a_in_tlast), .in_tuser_i(a_in_tuser),
        .out_tvalid_i(a_out_tvalid), .out_tready_i(a_out_tready),
        .out_tlast_i(a_out_tlast), .empty_i(a_empty),
        .wr_sel_o(a_wr_sel), .pop_line_o(a_pop), .flush_line_o(a_flush),
        .oldest_idx_o(a_oldest), .lines_cnt_o(a_cnt), .busy_o(a_busy)
    );

    line_buf_sched #(.LINES_NUM(5)) u_dut_b (
        .clk_i(clk_i), .rst_i(rst_i),
        .in_tvalid_i(b_in_tvalid), .in_tready_i(b_in_tready),
        .in_tlast_i(b_in_tlast), .in_tuser_i(b_in_tuser),
        .out_tvalid_i(b_out_tvalid), .out_tready_i(b_out_tready),
        .out_tlast_i(b_out_tlast), .empty_i(b_empty),
        .wr_sel_o(b_wr_sel), .pop_line_o(b_pop), .flush_line_o(b_flush),
        .oldest_idx_o(b_oldest), .lines_cnt_o(b_cnt), .busy_o(b_busy)
    );

    // Count pop pulses of the 5-line instance away from the active edge.
    always @(negedge clk_i) begin
        if (b_pop != '0) b_pops++;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic a_beat(input logic l, input logic u);
        a_in_tvalid = 1; a_in_tready = 1; a_in_tlast = l; a_in_tuser = u;
        tick();
        a_in_tvalid = 0; a_in_tready = 0; a_in_tlast = 0; a_in_tuser = 0;
    endtask

    task automatic a_line(input int len, input bit sof);
        for (int p = 0; p < len; p++) a_beat(p == len - 1, sof && (p == 0));
    endtask

    task automatic a_out_eol();
        a_out_tvalid = 1; a_out_tready = 1; a_out_tlast = 1;
        tick();
        a_out_tvalid = 0; a_out_tready = 0; a_out_tlast = 0;
    endtask

    task automatic b_line(input int len, input bit sof);
        for (int p = 0; p < len; p++) begin
            b_in_tvalid = 1; b_in_tready = 1;
            b_in_tlast = (p == len - 1); b_in_tuser = sof && (p == 0);
            tick();
            b_in_tvalid = 0; b_in_tready = 0; b_in_tlast = 0; b_in_tuser = 0;
        end
    endtask

    task automatic b_out_eol();
        b_out_tvalid = 1; b_out_tready = 1; b_out_tlast = 1;
        tick();
        b_out_tvalid = 0; b_out_tready = 0; b_out_tlast = 0;
    endtask

    initial begin
        bit seen;

        // ---------------- reset ----------------
        #1 rst_i = 1;
        #2;
        chk("rst_wr_sel", a_wr_sel, 3'b001);
        chk("rst_pop",    a_pop,    3'b000);
        chk("rst_flush",  a_flush,  3'b000);
        chk("rst_oldest", a_oldest, 0);
        chk("rst_cnt",    a_cnt,    0);
        chk("rst_busy",   a_busy,   0);
        chk("rst_b_wr_sel", b_wr_sel, 5'b00001);
        repeat (2) @(posedge clk_i);
        #1 rst_i = 0;
        tick();

        // ---------------- 1: fill three lines, pop 2 clk after last tlast ----
        a_line(8, 1);
        chk("t1_wr_sel_l1", a_wr_sel, 3'b010);
        chk("t1_cnt_l1",    a_cnt,    1);
        a_line(8, 0);
        chk("t1_wr_sel_l2", a_wr_sel, 3'b100);
        a_line(8, 0);
        chk("t1_wr_sel_l3", a_wr_sel, 3'b001);
        chk("t1_cnt_l3",    a_cnt,    3);
        chk("t1_pop_0clk",  a_pop,    3'b000);
        tick();
        chk("t1_pop_1clk",  a_pop,    3'b000);
        chk("t1_busy_pop",  a_busy,   1);
        tick();
        chk("t1_pop_2clk",  a_pop,    3'b111);
        tick();
        chk("t1_pop_pulse", a_pop,    3'b000);
        chk("t1_busy_send", a_busy,   1);

        // ---------------- 2: out eol -> flush oldest, 4th line pops ----------
        a_out_eol();
        chk("t2_flush_early", a_flush, 3'b000);
        tick();
        chk("t2_flush",   a_flush,  3'b001);
        chk("t2_oldest",  a_oldest, 1);
        chk("t2_wr_sel",  a_wr_sel, 3'b001);
        chk("t2_busy",    a_busy,   0);
        tick();
        chk("t2_flush_pulse", a_flush, 3'b000);
        a_line(8, 0);
        chk("t2_cnt_sat",  a_cnt,    3);
        chk("t2_wr_hold",  a_wr_sel, 3'b001);
        tick(); tick();
        chk("t2_pop4",     a_pop,    3'b111);
        chk("t2_oldest_p", a_oldest, 1);

        // ---------------- 3: SOF during SEND ----------------
        a_beat(0, 1);
        chk("t3_busy",   a_busy,   0);
        chk("t3_cnt",    a_cnt,    0);
        chk("t3_oldest", a_oldest, 0);
        chk("t3_wr_sel", a_wr_sel, 3'b001);
        chk("t3_pop",    a_pop,    3'b000);
        tick(); tick();
        chk("t3_no_flush", a_flush, 3'b000);

        // SOF beat that is also end-of-line
        a_beat(1, 1);
        chk("sofeol_cnt",    a_cnt,    1);
        chk("sofeol_wr_sel", a_wr_sel, 3'b010);

        // ---------------- 4: short frame, then recovery ----------------
        a_line(8, 1);
        chk("t4_cnt_l1", a_cnt, 1);
        a_line(8, 0);
        chk("t4_wr_sel_l2", a_wr_sel, 3'b100);
        seen = 0;
        for (int i = 0; i < 6; i++) begin
            tick();
            if (a_pop != 3'b000 || a_busy) seen = 1;
        end
        chk("t4_no_pop", seen, 0);
        chk("t4_cnt_l2", a_cnt, 2);
        a_beat(0, 1);
        chk("t4_sof_cnt",    a_cnt,    0);
        chk("t4_sof_wr_sel", a_wr_sel, 3'b001);
        for (int p = 1; p < 8; p++) a_beat(p == 7, 0);
        chk("t4_cnt_n1", a_cnt, 1);
        a_line(8, 0);
        a_empty = 3'b010;
        a_line(8, 0);
        chk("t4_cnt_n3", a_cnt, 3);
        tick(); tick(); tick();
        chk("t4_empty_hold_busy", a_busy, 0);
        chk("t4_empty_hold_pop",  a_pop,  3'b000);
        a_empty = 3'b000;
        tick();
        chk("t4_busy_pop", a_busy, 1);
        tick();
        chk("t4_pop", a_pop, 3'b111);

        // ---------------- 5: back-pressure in SEND ----------------
        a_out_tvalid = 1; a_out_tlast = 1; a_out_tready = 0;
        seen = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (a_flush != 3'b000 || !a_busy) seen = 1;
        end
        chk("t5_stall_no_flush", seen, 0);
        chk("t5_stall_wr_sel", a_wr_sel, 3'b001);
        a_out_tready = 1;
        tick();
        a_out_tvalid = 0; a_out_tlast = 0; a_out_tready = 0;
        chk("t5_flush_early", a_flush, 3'b000);
        tick();
        chk("t5_flush",  a_flush,  3'b001);
        chk("t5_oldest", a_oldest, 1);

        // ---------------- 6: 5-line window, 12 lines, reset mid-flush -------
        chk("t6_b_rst_cnt", b_cnt, 0);
        for (int l = 0; l < 12; l++) begin
            b_line(4, l == 0);
            if (l < 4) begin
                chk("t6_fill_wr_sel", b_wr_sel, 32'(1) << (l + 1));
                chk("t6_fill_cnt",    b_cnt,    l + 1);
            end else begin
                if (l == 4) begin
                    chk("t6_wrap_wr_sel", b_wr_sel, 5'b00001);
                    chk("t6_cnt_sat",     b_cnt,    5);
                end
                tick(); tick();
                chk("t6_pop",        b_pop,    5'b11111);
                chk("t6_oldest_pop", b_oldest, (l - 4) % 5);
                b_out_eol();
                if (l == 11) begin
                    chk("t6_busy_flush", b_busy, 1);
                    #2 rst_i = 1;
                    #1;
                    chk("t6_rst_wr_sel", b_wr_sel, 5'b00001);
                    chk("t6_rst_pop",    b_pop,    5'b00000);
                    chk("t6_rst_flush",  b_flush,  5'b00000);
                    chk("t6_rst_oldest", b_oldest, 0);
                    chk("t6_rst_cnt",    b_cnt,    0);
                    chk("t6_rst_busy",   b_busy,   0);
                    tick();
                    rst_i = 0;
                    tick();
                    chk("t6_post_rst_flush", b_flush, 5'b00000);
                    chk("t6_post_rst_busy",  b_busy,  0);
                end else begin
                    tick();
                    chk("t6_flush",   b_flush,  32'(1) << ((l - 4) % 5));
                    chk("t6_oldest",  b_oldest, (l - 3) % 5);
                    chk("t6_wr_sel",  b_wr_sel, 32'(1) << ((l - 4) % 5));
                end
            end
        end
        chk("t6_pop_count", b_pops, 8);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
